// File: rtl/throw_judge_pkg.sv
// Shared game geometry, hit-point constants and judge state encoding used by the
// trajectory, judge and draw blocks.
package throw_judge_pkg;

    localparam int unsigned COORD_W              = 32'd12;
    localparam int unsigned HP_W                 = 32'd3;

    localparam int unsigned GAME_GROUND_Y        = 32'd768;
    localparam int unsigned GAME_TARGET_TOP      = 32'd640;
    localparam int unsigned GAME_TARGET_W        = 32'd128;
    localparam int unsigned GAME_BALL_W          = 32'd32;
    localparam int unsigned GAME_BALL_H          = 32'd32;
    localparam int unsigned GAME_HP_INIT         = 32'd5;
    localparam int unsigned GAME_COOLDOWN_CYCLES = 32'd1024;
    localparam int unsigned GAME_TIMEOUT_CYCLES  = 32'd67108864;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RISE     = 2'd1,
        FALL     = 2'd2,
        COOLDOWN = 2'd3
    } judge_state_t;

    // One hit costs one point; an exhausted opponent stays at zero.
    function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp_now);
        logic [HP_W-1:0] hp_dec;
        hp_dec = hp_now - {{(HP_W-1){1'b0}}, 1'b1};
        return (hp_now == {HP_W{1'b0}}) ? hp_now : hp_dec;
    endfunction

endpackage

// File: rtl/hitbox_check.sv
// Combinational overlap test between the projectile sprite and the opponent hitbox.
// Sums are one bit wider than the coordinates so they never wrap.
module hitbox_check
    import throw_judge_pkg::*;
#(
    parameter int unsigned TARGET_TOP = GAME_TARGET_TOP,
    parameter int unsigned TARGET_W   = GAME_TARGET_W,
    parameter int unsigned BALL_W     = GAME_BALL_W,
    parameter int unsigned BALL_H     = GAME_BALL_H
) (
    input  logic [COORD_W-1:0] xpos_ball,
    input  logic [COORD_W-1:0] ypos_ball,
    input  logic [COORD_W-1:0] xpos_target,
    output logic               overlap
);

    localparam int unsigned EXT_W = COORD_W + 32'd1;

    localparam logic [EXT_W-1:0] BALL_W_EXT     = EXT_W'(BALL_W);
    localparam logic [EXT_W-1:0] BALL_H_EXT     = EXT_W'(BALL_H);
    localparam logic [EXT_W-1:0] TARGET_W_EXT   = EXT_W'(TARGET_W);
    localparam logic [EXT_W-1:0] TARGET_TOP_EXT = EXT_W'(TARGET_TOP);

    logic [EXT_W-1:0] ball_left_s;
    logic [EXT_W-1:0] ball_right_s;
    logic [EXT_W-1:0] ball_bottom_s;
    logic [EXT_W-1:0] target_left_s;
    logic [EXT_W-1:0] target_right_s;
    logic             x_overlap_s;
    logic             y_overlap_s;

    assign ball_left_s    = {1'b0, xpos_ball};
    assign ball_right_s   = {1'b0, xpos_ball} + BALL_W_EXT;
    assign ball_bottom_s  = {1'b0, ypos_ball} + BALL_H_EXT;
    assign target_left_s  = {1'b0, xpos_target};
    assign target_right_s = {1'b0, xpos_target} + TARGET_W_EXT;

    // Horizontal spans must intersect and the sprite bottom must reach the hitbox top.
    always_comb begin
        x_overlap_s = (ball_right_s > target_left_s) && (ball_left_s < target_right_s);
        y_overlap_s = (ball_bottom_s >= TARGET_TOP_EXT);
        overlap     = x_overlap_s && y_overlap_s;
    end

endmodule

// File: rtl/throw_judge.sv
// Throw judge: follows one projectile flight from launch to hit, ground miss or
// watchdog expiry, emits the end-of-throw/hit pulses and keeps the opponent's hit points.
module throw_judge
    import throw_judge_pkg::*;
#(
    parameter int unsigned GROUND_Y        = GAME_GROUND_Y,
    parameter int unsigned TARGET_TOP      = GAME_TARGET_TOP,
    parameter int unsigned TARGET_W        = GAME_TARGET_W,
    parameter int unsigned BALL_W          = GAME_BALL_W,
    parameter int unsigned BALL_H          = GAME_BALL_H,
    parameter int unsigned HP_INIT         = GAME_HP_INIT,
    parameter int unsigned COOLDOWN_CYCLES = GAME_COOLDOWN_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = GAME_TIMEOUT_CYCLES
) (
    input  logic               clk60MHz,
    input  logic               rst,
    input  logic               throw_start,
    input  logic               game_restart,
    input  logic [COORD_W-1:0] xpos_ball,
    input  logic [COORD_W-1:0] ypos_ball,
    input  logic [COORD_W-1:0] xpos_target,
    output logic               end_throw,
    output logic               hit,
    output logic [HP_W-1:0]    hp,
    output logic               game_over
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES : COOLDOWN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);
    localparam int unsigned EXT_W   = COORD_W + 32'd1;

    localparam logic [CNT_W-1:0]   CNT_ZERO       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   TIMEOUT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   COOLDOWN_LIMIT = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [EXT_W-1:0]   GROUND_LIMIT   = EXT_W'(GROUND_Y);
    localparam logic [HP_W-1:0]    HP_RELOAD      = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0]    HP_ZERO        = {HP_W{1'b0}};
    localparam logic [COORD_W-1:0] Y_ZERO         = {COORD_W{1'b0}};

    judge_state_t       state_r;
    judge_state_t       state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [COORD_W-1:0] y_prev_r;
    logic [COORD_W-1:0] y_prev_nxt_s;
    logic [HP_W-1:0]    hp_r;
    logic [HP_W-1:0]    hp_nxt_s;
    logic               end_throw_r;
    logic               end_throw_s;
    logic               hit_r;
    logic               hit_s;

    logic               overlap_s;
    logic               ground_s;
    logic               descending_s;
    logic               timeout_s;
    logic               cool_done_s;

    hitbox_check #(
        .TARGET_TOP (TARGET_TOP),
        .TARGET_W   (TARGET_W),
        .BALL_W     (BALL_W),
        .BALL_H     (BALL_H)
    ) u_hitbox_check (
        .xpos_ball   (xpos_ball),
        .ypos_ball   (ypos_ball),
        .xpos_target (xpos_target),
        .overlap     (overlap_s)
    );

    // Flight and cooldown conditions derived from the sampled inputs and the shared counter.
    always_comb begin
        ground_s     = ({1'b0, ypos_ball} >= GROUND_LIMIT);
        descending_s = (ypos_ball > y_prev_r);
        timeout_s    = (cnt_r >= TIMEOUT_LIMIT);
        cool_done_s  = (cnt_r >= COOLDOWN_LIMIT);
    end

    // State register; a reset mid-flight simply drops the throw.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; while waiting, ypos rests on the ground so nothing is judged.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (throw_start) begin
                    state_nxt_s = RISE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RISE: begin
                if (timeout_s) begin
                    state_nxt_s = COOLDOWN;
                end else if (descending_s) begin
                    state_nxt_s = FALL;
                end else begin
                    state_nxt_s = RISE;
                end
            end
            FALL: begin
                if (overlap_s || ground_s || timeout_s) begin
                    state_nxt_s = COOLDOWN;
                end else begin
                    state_nxt_s = FALL;
                end
            end
            COOLDOWN: begin
                if (cool_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = COOLDOWN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Per-state outputs and datapath updates; the counter serves as watchdog in flight
    // and as quiet-time meter in cooldown, where any throw request restarts the wait.
    always_comb begin
        end_throw_s  = 1'b0;
        hit_s        = 1'b0;
        cnt_nxt_s    = cnt_r;
        y_prev_nxt_s = y_prev_r;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (throw_start) begin
                    y_prev_nxt_s = ypos_ball;
                end else begin
                    y_prev_nxt_s = y_prev_r;
                end
            end
            RISE: begin
                y_prev_nxt_s = ypos_ball;
                end_throw_s  = timeout_s;
                cnt_nxt_s    = timeout_s ? CNT_ZERO : (cnt_r + CNT_ONE);
            end
            FALL: begin
                hit_s       = overlap_s;
                end_throw_s = overlap_s || ground_s || timeout_s;
                cnt_nxt_s   = end_throw_s ? CNT_ZERO : (cnt_r + CNT_ONE);
            end
            COOLDOWN: begin
                cnt_nxt_s = (throw_start || cool_done_s) ? CNT_ZERO : (cnt_r + CNT_ONE);
            end
            default: begin
                cnt_nxt_s = CNT_ZERO;
            end
        endcase

        // A restart reloads the points even when it lands on a hit.
        if (game_restart) begin
            hp_nxt_s = HP_RELOAD;
        end else if (hit_s) begin
            hp_nxt_s = hp_after_hit(hp_r);
        end else begin
            hp_nxt_s = hp_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            y_prev_r    <= Y_ZERO;
            hp_r        <= HP_RELOAD;
            end_throw_r <= 1'b0;
            hit_r       <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            y_prev_r    <= y_prev_nxt_s;
            hp_r        <= hp_nxt_s;
            end_throw_r <= end_throw_s;
            hit_r       <= hit_s;
        end
    end

    assign end_throw = end_throw_r;
    assign hit       = hit_r;
    assign hp        = hp_r;
    assign game_over = (hp_r == HP_ZERO);

endmodule
